// File: rtl/i2c_rd_arbiter.sv
// i2c_rd_arbiter
//   Round-robin arbiter/sequencer sharing one I2C master read engine between
//   NUM_REQ requesters. A request is a one-byte random read (7-bit device
//   address, 8-bit data address). The winner gets a grant pulse, its addresses
//   are handed to the engine with a start pulse, and the returned byte is routed
//   back as a response pulse. GAP_CYCLES of bus free time follow each response.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_valid         per-requester request level, held until grant
//   i_req_dev_addr      packed device addresses, requester k at [7k+6:7k]
//   i_req_data_addr     packed data addresses, requester k at [8k+7:8k]
//   o_req_grant         one-hot grant pulse (request accepted)
//   o_rsp_valid         one-hot response pulse
//   o_rsp_data          read byte, qualified by o_rsp_valid
//   o_rsp_err           timeout flag, qualified by o_rsp_valid
//   o_busy              high whenever the sequencer is not idle
//   o_eng_en            one-cycle engine start pulse
//   o_eng_dev_addr      engine device address, held until the next grant
//   o_eng_data_addr     engine data address, held until the next grant
//   i_eng_read_data     engine read byte, valid with i_eng_done
//   i_eng_done          engine completion (level or pulse)
//
// Optional build macro: I2C_ARB_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT_CYCLES; on expiry the response carries data 8'h00 and err = 1.

module i2c_rd_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] GAP_CYCLES     = 16'd250,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ*7-1:0]   i_req_dev_addr,
    input  logic [NUM_REQ*8-1:0]   i_req_data_addr,
    output logic [NUM_REQ-1:0]     o_req_grant,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    output logic [7:0]             o_rsp_data,
    output logic                   o_rsp_err,
    output logic                   o_busy,
    output logic                   o_eng_en,
    output logic [6:0]             o_eng_dev_addr,
    output logic [7:0]             o_eng_data_addr,
    input  logic [7:0]             i_eng_read_data,
    input  logic                   i_eng_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       last_grant_q, last_grant_d;
    logic [6:0]          dev_q, dev_d;
    logic [7:0]          dat_q, dat_d;
    logic                en_q, en_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q, rsp_data_d;
    logic [15:0]         gap_q, gap_d;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [23:0]         to_q, to_d;
    logic                rsp_err_q, rsp_err_d;
`else
    // Keeps the parameter referenced so both builds share one parameter list.
    localparam logic unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Round-robin search starting just above the last winner. The winner is
    // evaluated on the live request vector during GRANT, so a request dropped
    // before that cycle is simply not granted.
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [6:0]    win_dev;
    logic [7:0]    win_dat;
    int            k;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_dev   = '0;
        win_dat   = '0;
        k         = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(last_grant_q) + i) % NUM_REQ;
            if (!win_found && i_req_valid[k[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = PW'(k);
                win_dev   = i_req_dev_addr[7*k +: 7];
                win_dat   = i_req_data_addr[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dev_d        = dev_q;
        dat_d        = dat_q;
        en_d         = 1'b0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        gap_d        = gap_q;
`ifdef I2C_ARB_TIMEOUT_EN
        to_d         = to_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            S_IDLE:  if (|i_req_valid) state_d = S_GRANT;
            S_GRANT: begin
                if (win_found) begin
                    last_grant_d = win_idx;
                    dev_d        = win_dev;
                    dat_d        = win_dat;
                    en_d         = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // done during ISSUE belongs to no transaction of ours; ignored
                state_d = S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                to_d = '0;
`endif
            end
            S_WAIT: begin
                if (i_eng_done) begin
                    rsp_valid_d = ONE << last_grant_q;
                    rsp_data_d  = i_eng_read_data;
                    state_d     = S_RESP;
`ifdef I2C_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (to_q == TIMEOUT_CYCLES - 24'd1) begin
                    rsp_valid_d = ONE << last_grant_q;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    to_d = to_q + 24'd1;
`endif
                end
            end
            S_RESP: begin
                if (GAP_CYCLES == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_CYCLES - 16'd1) state_d = S_IDLE;
                else                             gap_d   = gap_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= PW'(NUM_REQ-1);
            dev_q        <= '0;
            dat_q        <= '0;
            en_q         <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            gap_q        <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            to_q         <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dev_q        <= dev_d;
            dat_q        <= dat_d;
            en_q         <= en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            gap_q        <= gap_d;
`ifdef I2C_ARB_TIMEOUT_EN
            to_q         <= to_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    // Grant is decoded from the GRANT state so it lands one cycle after the
    // request is seen and reflects the same vector the winner is taken from.
    assign o_req_grant     = (state_q == S_GRANT && win_found) ? (ONE << win_idx) : '0;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_data      = rsp_data_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_eng_en        = en_q;
    assign o_eng_dev_addr  = dev_q;
    assign o_eng_data_addr = dat_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign o_rsp_err       = rsp_err_q;
`else
    assign o_rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_rd_arbiter.sv
// Self-checking bench for i2c_rd_arbiter: directed scenarios plus a randomized
// round-robin run against a behavioural arbitration/scoreboard model.
module tb_i2c_rd_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   i_req_valid = '0;
    logic [27:0]  i_req_dev_addr = '0;
    logic [31:0]  i_req_data_addr = '0;
    logic [3:0]   o_req_grant, o_rsp_valid;
    logic [7:0]   o_rsp_data;
    logic         o_rsp_err, o_busy, o_eng_en;
    logic [6:0]   o_eng_dev_addr;
    logic [7:0]   o_eng_data_addr;
    logic [7:0]   i_eng_read_data = '0;
    logic         i_eng_done = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [6:0] m_dev [N];
    logic [7:0] m_dat [N];
    int         m_last;

    logic       eng_mute = 1'b0;
    int         eng_delay = 0;
    logic       eng_fix_en = 1'b0;
    logic [7:0] eng_fix_byte = '0;
    logic [7:0] eng_last_byte = '0;
    int         eng_d;

    i2c_rd_arbiter #(.NUM_REQ(N), .GAP_CYCLES(16'd16), .TIMEOUT_CYCLES(24'd1000)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_dev_addr(i_req_dev_addr),
        .i_req_data_addr(i_req_data_addr),
        .o_req_grant(o_req_grant), .o_rsp_valid(o_rsp_valid),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_busy(o_busy),
        .o_eng_en(o_eng_en), .o_eng_dev_addr(o_eng_dev_addr),
        .o_eng_data_addr(o_eng_data_addr),
        .i_eng_read_data(i_eng_read_data), .i_eng_done(i_eng_done)
    );

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        if (o_eng_en === 1'b1 && !eng_mute) begin
            eng_d = (eng_delay != 0) ? eng_delay : int'($urandom_range(1, 20));
            repeat (eng_d) @(negedge clk);
            eng_last_byte   = eng_fix_en ? eng_fix_byte : 8'($urandom);
            i_eng_read_data = eng_last_byte;
            i_eng_done      = 1'b1;
            @(negedge clk);
            i_eng_done      = 1'b0;
            i_eng_read_data = 8'($urandom);
        end
    end

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int i = 1; i <= N; i++)
            if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic set_req(input int r, input logic v, input logic [6:0] d, input logic [7:0] a);
        m_dev[r] = d;
        m_dat[r] = a;
        i_req_valid[r] = v;
        i_req_dev_addr[7*r +: 7]  = d;
        i_req_data_addr[8*r +: 8] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_last = N - 1;
        @(negedge clk);
    endtask

    task automatic wait_idle(output logic ok);
        int n = 0;
        while (o_busy && n < 500) begin @(negedge clk); n++; end
        ok = !o_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_req_grant, o_rsp_valid, o_eng_en, o_busy} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl got grant=%b rsp=%b en=%b busy=%b want all 0",
                     o_req_grant, o_rsp_valid, o_eng_en, o_busy);
        end
        checks++;
        if ({o_rsp_data, o_rsp_err, o_eng_dev_addr, o_eng_data_addr} !== 24'b0) begin
            errors++;
            $display("FAIL reset_data got data=%h err=%b dev=%h dat=%h want 0",
                     o_rsp_data, o_rsp_err, o_eng_dev_addr, o_eng_data_addr);
        end
        rst_n = 1'b1;
        m_last = N - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat = 0;
        logic ok;
        eng_delay = 600; eng_fix_en = 1'b1; eng_fix_byte = 8'hC3;
        set_req(1, 1'b1, 7'h50, 8'h1A);
        @(negedge clk);
        checks++;
        if (o_req_grant !== 4'b0010 || o_eng_en !== 1'b0) begin
            errors++;
            $display("FAIL single_grant got grant=%b en=%b want 0010/0", o_req_grant, o_eng_en);
        end
        @(negedge clk);
        checks++;
        if (o_eng_en !== 1'b1 || o_eng_dev_addr !== 7'h50 || o_eng_data_addr !== 8'h1A) begin
            errors++;
            $display("FAIL single_issue got en=%b dev=%h dat=%h want 1/50/1a",
                     o_eng_en, o_eng_dev_addr, o_eng_data_addr);
        end
        set_req(1, 1'b0, 7'h50, 8'h1A);
        while (o_rsp_valid === 4'b0 && lat < 2000) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 601) begin errors++; $display("FAIL single_latency got %0d want 601", lat); end
        checks++;
        if (o_rsp_valid !== 4'b0010 || o_rsp_data !== 8'hC3 || o_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got v=%b d=%h e=%b want 0010/c3/0",
                     o_rsp_valid, o_rsp_data, o_rsp_err);
        end
        m_last = 1;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_idle got busy want idle"); end
    endtask

    task automatic test_fairness();
        int n = 0, grants = 0, rsps = 0, last_rsp = -1;
        logic outst = 1'b0;
        logic ok;
        do_reset();
        eng_delay = 0; eng_fix_en = 1'b0;
        for (int r = 0; r < N; r++) set_req(r, 1'b1, 7'(r + 8), 8'(r * 17));
        while (rsps < 6 && n < 5000) begin
            @(negedge clk); n++;
            if (o_req_grant !== 4'b0) begin
                checks++;
                if (o_req_grant !== (4'b0001 << (grants % N))) begin
                    errors++;
                    $display("FAIL fair_order grant#%0d got %b want %b",
                             grants, o_req_grant, 4'b0001 << (grants % N));
                end
                if (last_rsp >= 0) begin
                    checks++;
                    if (n - last_rsp - 1 < 16) begin
                        errors++;
                        $display("FAIL fair_gap got %0d idle cycles want >=16", n - last_rsp - 1);
                    end
                end
                grants++;
            end
            if (o_eng_en === 1'b1) begin
                checks++;
                if (outst) begin errors++; $display("FAIL fair_overlap got en during wait want none"); end
                outst = 1'b1;
            end
            if (o_rsp_valid !== 4'b0) begin
                outst = 1'b0;
                last_rsp = n;
                rsps++;
            end
        end
        for (int r = 0; r < N; r++) set_req(r, 1'b0, m_dev[r], m_dat[r]);
        checks++;
        if (rsps != 6) begin errors++; $display("FAIL fair_count got %0d responses want 6", rsps); end
        m_last = 1;
        wait_idle(ok);
    endtask

    task automatic test_dropped();
        int grants = 0, ens = 0, rsps = 0;
        eng_delay = 30; eng_fix_en = 1'b0;
        set_req(0, 1'b1, 7'h21, 8'h42);
        @(negedge clk);
        checks++;
        if (o_req_grant !== 4'b0001) begin errors++; $display("FAIL drop_grant0 got %b want 0001", o_req_grant); end
        @(negedge clk);
        set_req(0, 1'b0, 7'h21, 8'h42);
        @(negedge clk);
        set_req(2, 1'b1, 7'h33, 8'h44);
        @(negedge clk);
        set_req(2, 1'b0, 7'h33, 8'h44);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_req_grant !== 4'b0) grants++;
            if (o_eng_en === 1'b1) ens++;
            if (o_rsp_valid !== 4'b0) rsps++;
        end
        checks++;
        if (grants != 0 || ens != 0) begin
            errors++;
            $display("FAIL drop_nogrant got grants=%0d en=%0d want 0/0", grants, ens);
        end
        checks++;
        if (rsps != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle got rsps=%0d busy=%b want 1/0", rsps, o_busy);
        end
        m_last = 0;
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        logic ok;
        eng_mute = 1'b1;
        set_req(0, 1'b1, 7'h11, 8'h22);
        @(negedge clk);
        checks++;
        if (o_req_grant !== 4'b0001) begin errors++; $display("FAIL rmid_grant got %b want 0001", o_req_grant); end
        @(negedge clk);
        set_req(0, 1'b0, 7'h11, 8'h22);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({o_req_grant, o_rsp_valid, o_eng_en, o_busy, o_rsp_data, o_eng_dev_addr, o_eng_data_addr} !== 33'b0) begin
                errors++;
                $display("FAIL rmid_outputs got g=%b v=%b en=%b busy=%b d=%h dev=%h dat=%h want 0",
                         o_req_grant, o_rsp_valid, o_eng_en, o_busy, o_rsp_data, o_eng_dev_addr, o_eng_data_addr);
            end
        end
        rst_n = 1'b1;
        eng_mute = 1'b0; eng_delay = 4; eng_fix_en = 1'b1; eng_fix_byte = 8'h9E;
        set_req(0, 1'b1, 7'h12, 8'h34);
        set_req(1, 1'b1, 7'h56, 8'h78);
        @(negedge clk);
        checks++;
        if (o_req_grant !== 4'b0001) begin errors++; $display("FAIL rmid_ptr got %b want 0001", o_req_grant); end
        @(negedge clk);
        set_req(0, 1'b0, 7'h12, 8'h34);
        set_req(1, 1'b0, 7'h56, 8'h78);
        while (o_rsp_valid === 4'b0 && lat < 200) begin @(negedge clk); lat++; end
        checks++;
        if (o_rsp_valid !== 4'b0001 || o_rsp_data !== 8'h9E) begin
            errors++;
            $display("FAIL rmid_rsp got v=%b d=%h want 0001/9e", o_rsp_valid, o_rsp_data);
        end
        m_last = 0;
        wait_idle(ok);
    endtask

    task automatic test_random();
        int n = 0, ntx = 0, drop_k = -1, w, exp_w = 0;
        logic [6:0] exp_dev = '0;
        logic [7:0] exp_dat = '0;
        logic ok;
        do_reset();
        eng_mute = 1'b0; eng_delay = 0; eng_fix_en = 1'b0;
        while (ntx < 30 && n < 20000) begin
            @(negedge clk); n++;
            if (drop_k >= 0) begin set_req(drop_k, 1'b0, m_dev[drop_k], m_dat[drop_k]); drop_k = -1; end
            if (o_req_grant !== 4'b0) begin
                w = rr_pick(m_last, i_req_valid);
                checks++;
                if (w < 0 || o_req_grant !== (4'b0001 << w)) begin
                    errors++;
                    $display("FAIL rand_grant got %b want idx %0d (valid=%b last=%0d)",
                             o_req_grant, w, i_req_valid, m_last);
                end
                if (w >= 0) begin
                    m_last = w; drop_k = w; exp_w = w;
                    exp_dev = m_dev[w]; exp_dat = m_dat[w];
                end
            end
            if (o_eng_en === 1'b1) begin
                checks++;
                if (o_eng_dev_addr !== exp_dev || o_eng_data_addr !== exp_dat) begin
                    errors++;
                    $display("FAIL rand_addr got %h/%h want %h/%h",
                             o_eng_dev_addr, o_eng_data_addr, exp_dev, exp_dat);
                end
            end
            if (o_rsp_valid !== 4'b0) begin
                checks++;
                if (o_rsp_valid !== (4'b0001 << exp_w) || o_rsp_data !== eng_last_byte || o_rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_rsp got %b/%h/%b want %b/%h/0", o_rsp_valid, o_rsp_data,
                             o_rsp_err, 4'b0001 << exp_w, eng_last_byte);
                end
                ntx++;
            end
            if (o_req_grant === 4'b0)
                for (int r = 0; r < N; r++)
                    if (!i_req_valid[r] && $urandom_range(0, 3) == 0)
                        set_req(r, 1'b1, 7'($urandom), 8'($urandom));
        end
        checks++;
        if (ntx < 30) begin errors++; $display("FAIL rand_budget got %0d transactions want 30", ntx); end
        for (int r = 0; r < N; r++) set_req(r, 1'b0, m_dev[r], m_dat[r]);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rand_idle got busy want idle"); end
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat = 0;
        logic ok;
        eng_mute = 1'b1;
        set_req(2, 1'b1, 7'h2A, 8'h55);
        @(negedge clk);
        @(negedge clk);
        set_req(2, 1'b0, 7'h2A, 8'h55);
        while (o_rsp_valid === 4'b0 && lat < 1200) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 1001) begin errors++; $display("FAIL to_latency got %0d want 1001", lat); end
        checks++;
        if (o_rsp_valid !== 4'b0100 || o_rsp_err !== 1'b1 || o_rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL to_rsp got %b/%h/%b want 0100/00/1", o_rsp_valid, o_rsp_data, o_rsp_err);
        end
        wait_idle(ok);
        eng_mute = 1'b0; eng_delay = 5; eng_fix_en = 1'b1; eng_fix_byte = 8'h5A;
        set_req(3, 1'b1, 7'h3B, 8'h66);
        @(negedge clk);
        @(negedge clk);
        set_req(3, 1'b0, 7'h3B, 8'h66);
        lat = 0;
        while (o_rsp_valid === 4'b0 && lat < 200) begin @(negedge clk); lat++; end
        checks++;
        if (o_rsp_valid !== 4'b1000 || o_rsp_err !== 1'b0 || o_rsp_data !== 8'h5A) begin
            errors++;
            $display("FAIL to_after got %b/%h/%b want 1000/5a/0", o_rsp_valid, o_rsp_data, o_rsp_err);
        end
        wait_idle(ok);
    endtask

    task automatic test_done_at_expiry();
        int lat = 0;
        logic ok;
        eng_mute = 1'b0; eng_delay = 1000; eng_fix_en = 1'b1; eng_fix_byte = 8'h77;
        set_req(1, 1'b1, 7'h4C, 8'h99);
        @(negedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 7'h4C, 8'h99);
        while (o_rsp_valid === 4'b0 && lat < 1200) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 1001 || o_rsp_err !== 1'b0 || o_rsp_data !== 8'h77) begin
            errors++;
            $display("FAIL to_tie got lat=%0d err=%b d=%h want 1001/0/77", lat, o_rsp_err, o_rsp_data);
        end
        wait_idle(ok);
    endtask
`endif

    initial begin
        for (int r = 0; r < N; r++) begin m_dev[r] = '0; m_dat[r] = '0; end
        m_last = N - 1;
        test_reset();
        test_single();
        test_fairness();
        test_dropped();
        test_reset_mid();
        test_random();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
        test_done_at_expiry();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
